regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
// - Parametrised multi-port register file with per-register scoreboard, write-to-read bypass and soft-clear sequencer.
// - Serves the next-generation datapath: NRD combinational read ports, two writeback ports (ALU, MEM).
// - Register 0 hardwired zero; busy bits let the issue stage stall on pending writes.
// PARAMETERS
// - DW     32  data width (bits)
// - DEPTH  32  number of registers; power of 2, >= 4
// - NRD    2   number of read ports, 1..4
// - AW     $clog2(DEPTH)  address width (derived localparam, not overridable)
// PORTS
// - inclk      in   1       clock, rising edge
// - rstn       in   1       reset, asynchronous, active-low
// - rd_addr    in   NRD*AW  read addresses, port k at [k*AW +: AW]
// - rd_data    out  NRD*DW  read data, port k at [k*DW +: DW]
// - rd_busy    out  NRD     port k register has a pending write
// - iss_v      in   1       issue: mark iss_rd busy
// - iss_rd     in   AW      issue destination register
// - wb0_v      in   1       writeback port 0 enable
// - wb0_addr   in   AW      writeback port 0 address
// - wb0_data   in   DW      writeback port 0 data
// - wb1_v      in   1       writeback port 1 enable (higher priority)
// - wb1_addr   in   AW      writeback port 1 address
// - wb1_data   in   DW      writeback port 1 data
// - clr_req    in   1       request soft clear of all registers and busy bits
// - clr_busy   out  1       soft clear in progress
// - clr_done   out  1       one-cycle pulse on last clear cycle
// BEHAVIOUR
// - Reset (rstn=0, async): all registers 0, all busy bits 0, FSM IDLE, clr_cnt 0, clr_busy 0, clr_done 0.
// - Read: combinational. Address 0 -> data 0, busy 0. Otherwise if wb1 hits addr -> wb1_data;
//   else if wb0 hits addr -> wb0_data; else array value (same-cycle bypass, zero latency).
// - rd_busy: busy bit of addr, cleared combinationally if wb0/wb1 hits addr this cycle; forced 0 during CLEAR.
// - Write: on inclk rising edge, wbX_v with addr!=0 writes array. Both ports same addr -> wb1 wins.
// - Scoreboard: busy[r] set on edge when iss_v & iss_rd==r & r!=0; cleared when any wb writes r.
//   Issue and writeback to same r in same cycle -> busy stays 1 (new producer wins); data still written.
// - iss_rd==0 and wb to addr 0 ignored; busy[0] constant 0.
// - FSM IDLE: clr_req=1 -> CLEAR next edge, clr_cnt=0. clr_req ignored while in CLEAR.
// - FSM CLEAR: clr_busy=1; each cycle reg[clr_cnt]=0, busy[clr_cnt]=0, clr_cnt++;
//   DEPTH cycles total; clr_done=1 in cycle clr_cnt==DEPTH-1; then IDLE.
// - During CLEAR: iss_v, wb0_v, wb1_v ignored (no write, no busy change); reads return array value,
//   bypass disabled. Caller must hold pipeline while clr_busy=1.
// - rstn asserted mid-CLEAR: immediate full reset as above; sequence not resumed.
// - clr_cnt is AW+1 bits wide to avoid wrap ambiguity at DEPTH-1.
// STRUCTURE
// - Shared package regfile_pkg: typedef enum {RF_IDLE, RF_CLEAR} rf_state_t; DW/DEPTH defaults.
// - Sub-module regfile_scoreboard (busy vector, set/clear priority, clear-by-index); array,
//   bypass mux and FSM stay in top.
// TESTING
// - Reset then read all regs on all ports -> rd_data 0, rd_busy 0, clr_busy 0.
// - wb0 addr 5 data 0xDEADBEEF; same cycle rd_addr[0]=5 -> 0xDEADBEEF (bypass); next cycle array holds it.
// - wb0 and wb1 both addr 7 (0x11, 0x22) -> read 0x22; write addr 0 data 0xFFFF -> reg 0 reads 0.
// - iss_v rd=3 -> rd_busy=1 next cycle; wb1 addr 3 -> rd_busy=0 same cycle; iss+wb same cycle rd=4 -> busy stays 1.
// - Fill regs 1..31 with index, clr_req 1 cycle -> clr_busy 32 cycles, clr_done on 32nd, all regs 0; wb during clear ignored.
// - Assert rstn=0 at clear cycle 10 -> all outputs reset immediately; clr_req again -> full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file slice.
package regfile_pkg;

   localparam int RF_DW_DEF    = 32;
   localparam int RF_DEPTH_DEF = 32;
   localparam int RF_NRD_DEF   = 2;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, soft-clear sweep clears by index.
module regfile_scoreboard #(
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             inclk,
   input  logic             rstn,
   input  logic             i_iss_v,
   input  logic [AW-1:0]    i_iss_rd,
   input  logic             i_wb0_v,
   input  logic [AW-1:0]    i_wb0_addr,
   input  logic             i_wb1_v,
   input  logic [AW-1:0]    i_wb1_addr,
   input  logic             i_clr_v,
   input  logic [AW-1:0]    i_clr_idx,
   output logic [DEPTH-1:0] o_busy
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Clear-by-index beats a new producer, which beats a retiring writeback.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 1; r < DEPTH; r++) begin
         if (i_clr_v && (i_clr_idx == AW'(r))) begin
            w_busy_nxt[r] = 1'b0;
         end else if (i_iss_v && (i_iss_rd == AW'(r))) begin
            w_busy_nxt[r] = 1'b1;
         end else if ((i_wb0_v && (i_wb0_addr == AW'(r))) ||
                      (i_wb1_v && (i_wb1_addr == AW'(r)))) begin
            w_busy_nxt[r] = 1'b0;
         end
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: combinational reads with writeback bypass, two write ports,
// issue scoreboard and a one-register-per-cycle soft-clear sequencer.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter  int DW    = RF_DW_DEF,
   parameter  int DEPTH = RF_DEPTH_DEF,
   parameter  int NRD   = RF_NRD_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              inclk,
   input  logic              rstn,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              iss_v,
   input  logic [AW-1:0]     iss_rd,
   input  logic              wb0_v,
   input  logic [AW-1:0]     wb0_addr,
   input  logic [DW-1:0]     wb0_data,
   input  logic              wb1_v,
   input  logic [AW-1:0]     wb1_addr,
   input  logic [DW-1:0]     wb1_data,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH-1);

   rf_state_t        r_state;
   rf_state_t        w_state_nxt;
   logic [AW:0]      r_clr_cnt;
   logic             w_clearing;
   logic             w_clr_last;
   logic             w_wb0_en;
   logic             w_wb1_en;
   logic             w_iss_en;
   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] w_busy;
   logic [DW-1:0]    w_rd_data [NRD];
   logic             w_rd_busy [NRD];

   assign w_clearing = (r_state == RF_CLEAR);
   assign w_clr_last = (r_clr_cnt == CLR_LAST);

   // Pipeline traffic has no effect while the sweep owns the array.
   assign w_wb0_en = wb0_v && !w_clearing && (wb0_addr != '0);
   assign w_wb1_en = wb1_v && !w_clearing && (wb1_addr != '0);
   assign w_iss_en = iss_v && !w_clearing && (iss_rd != '0);

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         r_state <= RF_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RF_IDLE:  if (clr_req) w_state_nxt = RF_CLEAR;
         RF_CLEAR: if (w_clr_last) w_state_nxt = RF_IDLE;
         default:  w_state_nxt = RF_IDLE;
      endcase
   end

   always_comb begin
      clr_busy = 1'b0;
      clr_done = 1'b0;
      if (r_state == RF_CLEAR) begin
         clr_busy = 1'b1;
         clr_done = w_clr_last;
      end
   end

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         r_clr_cnt <= '0;
      end else if (w_clearing) begin
         r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
      end else begin
         r_clr_cnt <= '0;
      end
   end

   // wb1 is written after wb0 so it wins a same-address collision.
   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_clearing) begin
         r_mem[r_clr_cnt[AW-1:0]] <= '0;
      end else begin
         if (w_wb0_en) r_mem[wb0_addr] <= wb0_data;
         if (w_wb1_en) r_mem[wb1_addr] <= wb1_data;
      end
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH)
   ) u_scoreboard (
      .inclk      (inclk),
      .rstn       (rstn),
      .i_iss_v    (w_iss_en),
      .i_iss_rd   (iss_rd),
      .i_wb0_v    (w_wb0_en),
      .i_wb0_addr (wb0_addr),
      .i_wb1_v    (w_wb1_en),
      .i_wb1_addr (wb1_addr),
      .i_clr_v    (w_clearing),
      .i_clr_idx  (r_clr_cnt[AW-1:0]),
      .o_busy     (w_busy)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_hit0;
      logic          w_hit1;

      assign w_addr = rd_addr[k*AW +: AW];
      assign w_hit0 = w_wb0_en && (wb0_addr == w_addr);
      assign w_hit1 = w_wb1_en && (wb1_addr == w_addr);

      always_comb begin
         if (w_addr == '0) begin
            w_rd_data[k] = '0;
         end else if (w_hit1) begin
            w_rd_data[k] = wb1_data;
         end else if (w_hit0) begin
            w_rd_data[k] = wb0_data;
         end else begin
            w_rd_data[k] = r_mem[w_addr];
         end
         w_rd_busy[k] = w_busy[w_addr] && !w_hit0 && !w_hit1 && !w_clearing;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data[k*DW +: DW] = w_rd_data[k];
         rd_busy[k]          = w_rd_busy[k];
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, clear/reset sequences,
// randomized traffic against an array-based reference model.
module tb_regfile_mp_sb;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic              inclk = 1'b0;
   logic              rstn;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              iss_v;
   logic [AW-1:0]     iss_rd;
   logic              wb0_v;
   logic [AW-1:0]     wb0_addr;
   logic [DW-1:0]     wb0_data;
   logic              wb1_v;
   logic [AW-1:0]     wb1_addr;
   logic [DW-1:0]     wb1_data;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   int n_checks = 0;
   int n_err    = 0;

   regfile_mp_sb #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD)) dut (
      .inclk    (inclk),
      .rstn     (rstn),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .iss_v    (iss_v),
      .iss_rd   (iss_rd),
      .wb0_v    (wb0_v),
      .wb0_addr (wb0_addr),
      .wb0_data (wb0_data),
      .wb1_v    (wb1_v),
      .wb1_addr (wb1_addr),
      .wb1_data (wb1_data),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   // clock / reset
   always #5 inclk = ~inclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: plain arrays plus a "sweep position" for the soft clear
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_busy [DEPTH];
   bit            m_clr;
   int            m_idx;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_clr = 1'b0;
      m_idx = 0;
   endfunction

   function automatic void model_update();
      if (!rstn) begin
         model_reset();
         return;
      end
      if (m_clr) begin
         m_mem[m_idx]  = '0;
         m_busy[m_idx] = 1'b0;
         if (m_idx == DEPTH-1) m_clr = 1'b0;
         else m_idx++;
      end else begin
         if (wb0_v && wb0_addr != 0) begin
            m_mem[wb0_addr]  = wb0_data;
            m_busy[wb0_addr] = 1'b0;
         end
         if (wb1_v && wb1_addr != 0) begin
            m_mem[wb1_addr]  = wb1_data;
            m_busy[wb1_addr] = 1'b0;
         end
         if (iss_v && iss_rd != 0) m_busy[iss_rd] = 1'b1;
         if (clr_req) begin
            m_clr = 1'b1;
            m_idx = 0;
         end
      end
   endfunction

   function automatic void model_read(input int a, output logic [DW-1:0] d, output logic b);
      if (a == 0) begin
         d = '0; b = 1'b0;
      end else if (m_clr) begin
         d = m_mem[a]; b = 1'b0;
      end else if (wb1_v && int'(wb1_addr) == a) begin
         d = wb1_data; b = 1'b0;
      end else if (wb0_v && int'(wb0_addr) == a) begin
         d = wb0_data; b = 1'b0;
      end else begin
         d = m_mem[a]; b = m_busy[a];
      end
   endfunction

   // scoreboard helpers
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [DW-1:0] d;
      logic          b;
      for (int k = 0; k < NRD; k++) begin
         model_read(int'(rd_addr[k*AW +: AW]), d, b);
         chk($sformatf("%s rd_data[%0d]", tag, k), rd_data[k*DW +: DW], d);
         chk1($sformatf("%s rd_busy[%0d]", tag, k), rd_busy[k], b);
      end
      chk1({tag, " clr_busy"}, clr_busy, m_clr);
      chk1({tag, " clr_done"}, clr_done, m_clr && (m_idx == DEPTH-1));
   endtask

   // driver tasks
   task automatic tick();
      model_update();
      @(posedge inclk);
      #1;
   endtask

   task automatic drive_idle();
      iss_v = 1'b0; iss_rd = '0;
      wb0_v = 1'b0; wb0_addr = '0; wb0_data = '0;
      wb1_v = 1'b0; wb1_addr = '0; wb1_data = '0;
      clr_req = 1'b0;
   endtask

   task automatic run_clear(input string tag);
      int cycles;
      int done_at;
      cycles  = 0;
      done_at = -1;
      #1;
      while (clr_busy === 1'b1 && cycles < 100) begin
         check_outputs(tag);
         if (clr_done === 1'b1) done_at = cycles;
         tick();
         cycles++;
         #1;
      end
      chk({tag, " busy_cycles"}, DW'(cycles), DW'(DEPTH));
      chk({tag, " done_cycle"}, DW'(done_at), DW'(DEPTH-1));
   endtask

   typedef struct {
      logic          wb0_v;
      logic [AW-1:0] wb0_a;
      logic [DW-1:0] wb0_d;
      logic          wb1_v;
      logic [AW-1:0] wb1_a;
      logic [DW-1:0] wb1_d;
      logic          iss_v;
      logic [AW-1:0] iss_rd;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] exp_d0;
      logic          exp_b0;
      logic [DW-1:0] exp_d1;
      logic          exp_b1;
   } vec_t;

   vec_t vecs [14];

   initial begin
      // directed vectors, applied from the all-zero reset state, one cycle each
      vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
      vecs[2]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,   1'b0, 5'd0, 5'd7, 5'd5, 32'h22,       1'b0, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        1'b0, 32'h22,       1'b0};
      vecs[4]  = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        1'b1, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 5'd3, 5'd5, 32'hAAAA,     1'b0, 32'hDEADBEEF, 1'b0};
      vecs[8]  = '{1'b1, 5'd4, 32'h4444,     1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 5'd4, 5'd3, 32'h4444,     1'b0, 32'hAAAA,     1'b0};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd4, 5'd4, 32'h4444,     1'b1, 32'h4444,     1'b1};
      vecs[10] = '{1'b1, 5'd4, 32'h5555,     1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd4, 5'd0, 32'h5555,     1'b0, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd4, 5'd3, 32'h5555,     1'b0, 32'hAAAA,     1'b0};
      vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd7, 32'h0,        1'b0, 32'h22,       1'b0};
      vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd4, 32'h0,        1'b0, 32'h5555,     1'b0};

      rstn = 1'b0;
      rd_addr = '0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge inclk);
      #1;
      rstn = 1'b1;
      tick();

      // reset state on every register, both ports
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(DEPTH-1-a), AW'(a)};
         #1;
         chk($sformatf("reset rd_data0 a=%0d", a), rd_data[DW-1:0], '0);
         chk($sformatf("reset rd_data1 a=%0d", a), rd_data[2*DW-1:DW], '0);
         chk1($sformatf("reset rd_busy a=%0d", a), |rd_busy, 1'b0);
         chk1("reset clr_busy", clr_busy, 1'b0);
         tick();
      end

      // directed vector table
      for (int i = 0; i < 14; i++) begin
         wb0_v = vecs[i].wb0_v; wb0_addr = vecs[i].wb0_a; wb0_data = vecs[i].wb0_d;
         wb1_v = vecs[i].wb1_v; wb1_addr = vecs[i].wb1_a; wb1_data = vecs[i].wb1_d;
         iss_v = vecs[i].iss_v; iss_rd = vecs[i].iss_rd;
         rd_addr = {vecs[i].ra1, vecs[i].ra0};
         #1;
         chk($sformatf("vec%0d rd_data0", i), rd_data[DW-1:0], vecs[i].exp_d0);
         chk1($sformatf("vec%0d rd_busy0", i), rd_busy[0], vecs[i].exp_b0);
         chk($sformatf("vec%0d rd_data1", i), rd_data[2*DW-1:DW], vecs[i].exp_d1);
         chk1($sformatf("vec%0d rd_busy1", i), rd_busy[1], vecs[i].exp_b1);
         tick();
      end
      drive_idle();

      // fill regs with their index; reg 6 gets issue+writeback together
      for (int a = 1; a < DEPTH; a++) begin
         wb0_v = 1'b1; wb0_addr = AW'(a); wb0_data = DW'(a);
         iss_v = (a == 6); iss_rd = AW'(a);
         rd_addr = {AW'(a), AW'(a-1)};
         #1;
         check_outputs("fill");
         tick();
      end
      drive_idle();
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(a), AW'(a)};
         #1;
         chk($sformatf("fill_rd a=%0d", a), rd_data[DW-1:0], DW'(a));
         chk1($sformatf("fill_busy a=%0d", a), rd_busy[1], a == 6);
         tick();
      end

      // soft clear with pipeline traffic that must be ignored
      clr_req = 1'b1;
      #1;
      check_outputs("clr_req");
      tick();
      clr_req = 1'b0;
      wb1_v = 1'b1; wb1_addr = 5'd9;  wb1_data = 32'hBAD0BAD0;
      wb0_v = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h0BADF00D;
      iss_v = 1'b1; iss_rd = 5'd11;
      rd_addr = {5'd10, 5'd9};
      run_clear("clear");
      drive_idle();
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(a), AW'(a)};
         #1;
         chk($sformatf("post_clear a=%0d", a), rd_data[DW-1:0], '0);
         chk1($sformatf("post_clear_busy a=%0d", a), rd_busy[0], 1'b0);
         tick();
      end

      // reset asserted mid-sweep, then a fresh full sweep
      for (int a = 1; a <= 12; a++) begin
         wb0_v = 1'b1; wb0_addr = AW'(a); wb0_data = DW'(32'h100 + a);
         tick();
      end
      drive_idle();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      rd_addr = {5'd5, 5'd12};
      for (int c = 0; c < 10; c++) begin
         #1;
         check_outputs("clear_pre_rst");
         tick();
      end
      #1;
      chk("pre_rst rd_data0", rd_data[DW-1:0], 32'h10C);
      chk1("pre_rst clr_busy", clr_busy, 1'b1);
      rstn = 1'b0;
      #1;
      model_reset();
      chk("rst rd_data0", rd_data[DW-1:0], '0);
      chk("rst rd_data1", rd_data[2*DW-1:DW], '0);
      chk1("rst clr_busy", clr_busy, 1'b0);
      chk1("rst clr_done", clr_done, 1'b0);
      tick();
      rstn = 1'b1;
      #1;
      chk("after_rst rd_data0", rd_data[DW-1:0], '0);
      chk1("after_rst clr_busy", clr_busy, 1'b0);
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      run_clear("clear2");

      // randomized traffic, occasional soft clears
      for (int n = 0; n < 400; n++) begin
         wb0_v = $urandom_range(0, 1);
         wb0_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         wb0_data = $urandom;
         wb1_v = $urandom_range(0, 1);
         wb1_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         wb1_data = $urandom;
         iss_v = $urandom_range(0, 1);
         iss_rd = AW'($urandom_range(0, 7));
         clr_req = ($urandom_range(0, 59) == 0);
         rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         #1;
         check_outputs("rand");
         tick();
      end
      drive_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
